// File: rtl/pattern_defs.sv
// Shared definitions for the serial pattern link (generator and detector).
// Both ends import the default pattern from here so they stay in sync.
package pattern_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int         DEF_PAT_W   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;

endpackage

// File: rtl/pattern_shift_reg.sv
// Parallel-load register that shifts its contents out MSB first.
// Zero fill keeps bit_out low once the pattern has been emptied.
module pattern_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         bit_out
);

  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

  assign bit_out = q[W-1];

endmodule

// File: rtl/serial_pattern_generator.sv
// Transmit side of the serial pattern link: repeats a pattern
// MSB first with an optional idle gap between copies.
module serial_pattern_generator
  import pattern_defs::*;
#(
  parameter int             PAT_W       = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = DEF_PATTERN,
  parameter int             CNT_W       = 8,
  parameter int             GAP_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_default,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  output logic             X,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MAX =
    IDX_W'(PAT_W - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic [GAP_W-1:0] gcnt, gcnt_n;
  logic [PAT_W-1:0] pat_q, pat_n;
  logic             done_q, done_n;

  logic             sr_clear;
  logic             sr_load;
  logic             sr_shift;
  logic [PAT_W-1:0] sr_d;
  logic             sr_msb;

  pattern_shift_reg #(
    .W(PAT_W)
  ) u_sreg (
    .clk    (clk),
    .reset  (reset),
    .clear  (sr_clear),
    .load   (sr_load),
    .shift  (sr_shift),
    .d      (sr_d),
    .bit_out(sr_msb)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      gap_q  <= '0;
      gcnt   <= '0;
      pat_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      gap_q  <= gap_n;
      gcnt   <= gcnt_n;
      pat_q  <= pat_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    gap_n    = gap_q;
    gcnt_n   = gcnt;
    pat_n    = pat_q;
    done_n   = 1'b0;
    sr_clear = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_d     = pat_q;

    if (abort && state != IDLE) begin
      state_n  = IDLE;
      idx_n    = '0;
      cnt_n    = '0;
      gcnt_n   = '0;
      sr_clear = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            pat_n   = use_default ? PAT_DEFAULT
                                  : pattern;
            sr_d    = pat_n;
            sr_load = 1'b1;
            cnt_n   = repeat_cnt;
            gap_n   = gap_len;
            idx_n   = IDX_MAX;
            state_n = SHIFT;
          end
        end
        SHIFT: begin
          if (idx != '0) begin
            idx_n    = idx - 1'b1;
            sr_shift = 1'b1;
          end else if (cnt == CNT_W'(1)) begin
            state_n  = IDLE;
            cnt_n    = '0;
            done_n   = 1'b1;
            sr_clear = 1'b1;
          end else begin
            // a latched count of zero means run forever
            if (cnt != '0) cnt_n = cnt - 1'b1;
            if (gap_q != '0) begin
              state_n  = GAP;
              gcnt_n   = gap_q;
              sr_clear = 1'b1;
            end else begin
              sr_load = 1'b1;
              idx_n   = IDX_MAX;
            end
          end
        end
        GAP: begin
          if (gcnt <= GAP_W'(1)) begin
            state_n = SHIFT;
            gcnt_n  = '0;
            sr_load = 1'b1;
            idx_n   = IDX_MAX;
          end else begin
            gcnt_n = gcnt - 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign X       = sr_msb;
  assign x_valid = (state == SHIFT);
  assign busy    = (state != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Bench for serial_pattern_generator: per-cycle model of the
// output stream plus literal checks on a few known streams.
module tb_serial_pattern_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       use_default;
  logic [3:0] pattern;
  logic [7:0] repeat_cnt;
  logic [3:0] gap_len;
  logic       abort;
  logic       X;
  logic       x_valid;
  logic       busy;
  logic       done;

  serial_pattern_generator dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .use_default(use_default),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
    .abort      (abort),
    .X          (X),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // expected {X, x_valid, busy, done} per cycle
  logic [3:0] exp_q[$];
  logic [3:0] mdl[$];
  bit         obs[$];
  int         det[$];
  logic [3:0] win;
  int         done_cnt;
  int         n_chk;
  int         n_fail;
  int         cyc;
  bit         chk_en;

  initial begin
    n_chk = 0;
    n_fail = 0;
    done_cnt = 0;
    cyc = 0;
    chk_en = 1'b0;
    win = '0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] e;
      logic [3:0] got;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 4'b0000;
      got = {X, x_valid, busy, done};
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL stream cyc %0d: X/v/b/d got %b required %b",
                 cyc, got, e);
      end
      if (x_valid === 1'b1) begin
        obs.push_back(X);
        win = {win[2:0], X};
        if (win == 4'b1011) det.push_back(obs.size() - 1);
      end
      if (done === 1'b1) done_cnt++;
      cyc++;
    end
  end

  task automatic chk(input string name, input int got,
                     input int req);
    n_chk++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  // Stream model straight from the link rules: PAT_W bits per copy,
  // gap cycles between copies, one done cycle after the final copy.
  function automatic void build(input logic ud,
                                input logic [3:0] p,
                                input logic [7:0] rc,
                                input logic [3:0] g,
                                input int stop);
    logic [3:0] pt;
    int copies;
    pt = ud ? 4'b1011 : p;
    copies = (rc == 0) ? stop : int'(rc);
    mdl.delete();
    for (int c = 0; c < copies; c++) begin
      for (int b = 3; b >= 0; b--)
        mdl.push_back({pt[b], 3'b110});
      if (c == copies - 1) begin
        if (rc != 0) mdl.push_back(4'b0001);
      end else begin
        for (int k = 0; k < int'(g); k++)
          mdl.push_back(4'b0010);
      end
    end
    if (stop > 0)
      while (mdl.size() > stop) void'(mdl.pop_back());
  endfunction

  function automatic int packed_obs();
    int v;
    v = 0;
    foreach (obs[i]) v = (v << 1) | int'(obs[i]);
    return v;
  endfunction

  // Caller is at negedge+1. stop>0 kills the run after that many
  // output cycles, by reset if kill_rst else by abort.
  task automatic run(input logic ud, input logic [3:0] p,
                     input logic [7:0] rc, input logic [3:0] g,
                     input int stop, input bit kill_rst,
                     input bit poke);
    int total;
    build(ud, p, rc, g, stop);
    total = mdl.size();
    foreach (mdl[i]) exp_q.push_back(mdl[i]);
    obs.delete();
    det.delete();
    win = '0;
    done_cnt = 0;
    use_default = ud;
    pattern = p;
    repeat_cnt = rc;
    gap_len = g;
    start = 1'b1;
    for (int i = 0; i < total + 3; i++) begin
      @(negedge clk);
      #1;
      if (i == 0) start = 1'b0;
      if (poke && i == 2) begin
        start = 1'b1;
        pattern = ~p;
        use_default = ~ud;
        repeat_cnt = 8'd5;
        gap_len = 4'd7;
      end
      if (poke && i == 3) start = 1'b0;
      if (stop > 0 && i == stop - 1) begin
        if (kill_rst) reset = 1'b0;
        else abort = 1'b1;
      end
      if (stop > 0 && i == stop) begin
        reset = 1'b1;
        abort = 1'b0;
      end
    end
    chk("queue drained", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    use_default = 1'b0;
    pattern = '0;
    repeat_cnt = '0;
    gap_len = '0;
    abort = 1'b0;

    build(1'b1, 4'b0000, 8'd1, 4'd0, 0);
    chk("model t1 len", mdl.size(), 5);
    chk("model t1 bits",
        {mdl[0][3], mdl[1][3], mdl[2][3], mdl[3][3]}, 4'b1011);
    build(1'b0, 4'b1100, 8'd3, 4'd2, 0);
    chk("model t2 len", mdl.size(), 17);
    chk("model t2 gap", mdl[4], 4'b0010);
    chk("model t2 done", mdl[16], 4'b0001);

    @(negedge clk);
    @(negedge clk);
    #1;
    chk_en = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    #1;

    run(1'b1, 4'b0000, 8'd1, 4'd0, 0, 1'b0, 1'b0);
    chk("t1 bits", packed_obs(), 'b1011);
    chk("t1 nbits", obs.size(), 4);
    chk("t1 done", done_cnt, 1);

    run(1'b0, 4'b1100, 8'd3, 4'd2, 0, 1'b0, 1'b0);
    chk("t2 bits", packed_obs(), 'b110011001100);
    chk("t2 done", done_cnt, 1);

    run(1'b1, 4'b0000, 8'd0, 4'd0, 10, 1'b0, 1'b0);
    chk("t3 bits", packed_obs(), 'b1011101110);
    chk("t3 nbits", obs.size(), 10);
    chk("t3 no done", done_cnt, 0);

    run(1'b0, 4'b1110, 8'd2, 4'd1, 3, 1'b1, 1'b0);
    chk("t4 bits", packed_obs(), 'b111);
    chk("t4 no done", done_cnt, 0);
    run(1'b0, 4'b0110, 8'd1, 4'd0, 0, 1'b0, 1'b0);
    chk("t4 restart", packed_obs(), 'b0110);

    run(1'b0, 4'b1001, 8'd2, 4'd1, 0, 1'b0, 1'b1);
    chk("t5 bits", packed_obs(), 'b10011001);
    chk("t5 done", done_cnt, 1);

    run(1'b1, 4'b0000, 8'd2, 4'd0, 0, 1'b0, 1'b0);
    chk("t6 ndet", det.size(), 2);
    if (det.size() == 2) begin
      chk("t6 det0", det[0], 3);
      chk("t6 det1", det[1], 7);
    end
    chk("t6 done", done_cnt, 1);

    repeat (3) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
